// File: rtl/subckt_pkg.sv
// rtl/subckt_pkg.sv - shared polynomials, FSM state type and step functions for the pattern driver
package subckt_pkg;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Galois right-shift LFSR: taps fold back in when the bit shifted out is set
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 16'h0000);
  endfunction

  // Serial-input MISR: left shift with feedback, then fold the new response bit into bit 0
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {15'b0, d};
  endfunction

endpackage

// File: rtl/subckt_misr.sv
// rtl/subckt_misr.sv - 16-bit serial-input MISR with synchronous clear and enable
module subckt_misr
  import subckt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);

  // Clear wins over enable so a new run always compacts from a zero signature
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/subckt_pattern_driver.sv
// rtl/subckt_pattern_driver.sv - LFSR pattern source and MISR response sink for a sub-circuit; SUBCKT_TOGGLE_CNT_EN adds toggle_cnt
module subckt_pattern_driver
  import subckt_pkg::*;
#(
  parameter int          N_IN    = 4,
  parameter int          NUM_PAT = 256,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [N_IN-1:0]              pat_out,
  input  logic                         resp_in,
  output logic [15:0]                  signature,
  output logic [$clog2(NUM_PAT+1)-1:0] pat_cnt
`ifdef SUBCKT_TOGGLE_CNT_EN
  ,
  output logic [31:0]                  toggle_cnt
`endif
);

  localparam int               CNT_W    = $clog2(NUM_PAT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_PAT);

  if (NUM_PAT < 1) begin : g_bad_num_pat
    $error("subckt_pattern_driver: NUM_PAT must be at least 1");
  end
  if (N_IN < 1 || N_IN > 16) begin : g_bad_n_in
    $error("subckt_pattern_driver: N_IN must be in 1..16");
  end

  state_t      state_q;
  state_t      state_d;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        accept;
  logic        running;
  logic        last_pat;

  assign accept    = (state_q == IDLE) && start;
  assign running   = (state_q == RUN);
  assign last_pat  = running && (pat_cnt == LAST_CNT);
  assign lfsr_next = lfsr_step(lfsr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start only matters in IDLE, DONE always falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // LFSR, pattern register and pattern counter; pat_out is forced to zero on the way into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= SEED;
      pat_cnt <= '0;
      pat_out <= '0;
    end else if (accept) begin
      lfsr    <= SEED;
      pat_cnt <= '0;
      pat_out <= SEED[N_IN-1:0];
    end else if (running) begin
      lfsr <= lfsr_next;
      if (pat_cnt != MAX_CNT) begin
        pat_cnt <= pat_cnt + CNT_W'(1);
      end
      pat_out <= last_pat ? '0 : lfsr_next[N_IN-1:0];
    end
  end

  subckt_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (running),
    .din   (resp_in),
    .sig   (signature)
  );

`ifdef SUBCKT_TOGGLE_CNT_EN
  logic [N_IN-1:0] prev_pat;
  logic [32:0]     toggle_sum;

  assign toggle_sum = {1'b0, toggle_cnt} + 33'($countones(pat_out ^ prev_pat));

  // prev_pat trails pat_out by one cycle and is zero on the first RUN cycle, so the IDLE->first edge counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pat   <= '0;
      toggle_cnt <= '0;
    end else begin
      prev_pat <= pat_out;
      if (accept) begin
        toggle_cnt <= '0;
      end else if (running) begin
        toggle_cnt <= toggle_sum[32] ? '1 : toggle_sum[31:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_subckt_pattern_driver.sv
// tb/tb_subckt_pattern_driver.sv - self-checking bench for subckt_pattern_driver (three parameterisations)
module tb_subckt_pattern_driver;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_v [3];
  logic        start_v[3];
  logic        resp_v [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic [3:0]  pat_v  [3];
  logic [15:0] sig_v  [3];
  logic [8:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic [2:0]  cnt_c;
  int          cnt_v  [3];
`ifdef SUBCKT_TOGGLE_CNT_EN
  logic [31:0] tog_v  [3];
`endif

  int errors = 0;
  int checks = 0;

  always_comb begin
    cnt_v[0] = int'(cnt_a);
    cnt_v[1] = int'(cnt_b);
    cnt_v[2] = int'(cnt_c);
  end

  subckt_pattern_driver #(.N_IN(4), .NUM_PAT(256), .SEED(SEED)) dut_a (
    .clk(clk), .rst_n(rstn_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pat_out(pat_v[0]), .resp_in(resp_v[0]), .signature(sig_v[0]), .pat_cnt(cnt_a)
`ifdef SUBCKT_TOGGLE_CNT_EN
    , .toggle_cnt(tog_v[0])
`endif
  );

  subckt_pattern_driver #(.N_IN(4), .NUM_PAT(2), .SEED(SEED)) dut_b (
    .clk(clk), .rst_n(rstn_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pat_out(pat_v[1]), .resp_in(resp_v[1]), .signature(sig_v[1]), .pat_cnt(cnt_b)
`ifdef SUBCKT_TOGGLE_CNT_EN
    , .toggle_cnt(tog_v[1])
`endif
  );

  subckt_pattern_driver #(.N_IN(4), .NUM_PAT(4), .SEED(SEED)) dut_c (
    .clk(clk), .rst_n(rstn_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pat_out(pat_v[2]), .resp_in(resp_v[2]), .signature(sig_v[2]), .pat_cnt(cnt_c)
`ifdef SUBCKT_TOGGLE_CNT_EN
    , .toggle_cnt(tog_v[2])
`endif
  );

  typedef struct {
    logic        start;
    logic        resp;
    logic        busy;
    logic        done;
    logic [3:0]  pat;
    int          cnt;
    logic [15:0] sig;
    logic        tog_ok;
    logic [31:0] tog;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [15:0] m_lfsr(input logic [15:0] v);
    int x;
    x = int'(v);
    return 16'((x / 2) ^ (((x % 2) != 0) ? 'hB400 : 0));
  endfunction

  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic d);
    int x;
    x = int'(s) * 2;
    if (x >= 65536) x = (x - 65536) ^ 'h1021;
    return 16'(x ^ int'(d));
  endfunction

  function automatic int popcnt(input logic [3:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic gold(input logic [3:0] p);
    return (p[1] ~^ p[2]) & ((p[0] & p[3]) | (p[0] ^ p[1]));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 resp=0, 1 resp=1, 2 random resp, 3 golden sub-circuit
  task automatic run_check(input int u, input int np, input int mode);
    logic [15:0] l;
    logic [15:0] ms;
    logic [15:0] mbad;
    logic [3:0]  p;
    logic [3:0]  prev;
    logic        r;
    int          tog;
    l = SEED; ms = '0; mbad = '0; prev = '0; tog = 0;
    start_v[u] = 1'b1;
    @(negedge clk);
    start_v[u] = 1'b0;
    for (int k = 1; k <= np; k++) begin
      p = l[3:0];
      chk($sformatf("u%0d_pat%0d", u, k), 32'(pat_v[u]), 32'(p));
      chk($sformatf("u%0d_busy_run%0d", u, k), 32'(busy_v[u]), 32'd1);
      chk($sformatf("u%0d_done_run%0d", u, k), 32'(done_v[u]), 32'd0);
      case (mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        2:       r = 1'($urandom_range(0, 1));
        default: r = gold(p);
      endcase
      resp_v[u] = (mode == 3) ? gold(pat_v[u]) : r;
      ms   = m_misr(ms, r);
      mbad = m_misr(mbad, (k == (np + 1) / 2) ? ~r : r);
      tog += popcnt(p ^ prev);
      prev = p;
      l = m_lfsr(l);
      @(negedge clk);
    end
    resp_v[u] = 1'b0;
    chk($sformatf("u%0d_done_pulse", u), 32'(done_v[u]), 32'd1);
    chk($sformatf("u%0d_busy_done", u), 32'(busy_v[u]), 32'd1);
    chk($sformatf("u%0d_pat_done", u), 32'(pat_v[u]), 32'd0);
    chk($sformatf("u%0d_cnt_done", u), 32'(cnt_v[u]), 32'(np));
    chk($sformatf("u%0d_sig_done", u), 32'(sig_v[u]), 32'(ms));
`ifdef SUBCKT_TOGGLE_CNT_EN
    chk($sformatf("u%0d_toggle", u), tog_v[u], 32'(tog));
`endif
    if (mode == 3) begin
      checks++;
      if (sig_v[u] == mbad) begin
        errors++;
        $display("FAIL u%0d_fault_model: signature %0h equals faulty-model %0h", u, sig_v[u], mbad);
      end
    end
    @(negedge clk);
    chk($sformatf("u%0d_done_after", u), 32'(done_v[u]), 32'd0);
    chk($sformatf("u%0d_busy_after", u), 32'(busy_v[u]), 32'd0);
    chk($sformatf("u%0d_sig_hold", u), 32'(sig_v[u]), 32'(ms));
    chk($sformatf("u%0d_cnt_hold", u), 32'(cnt_v[u]), 32'(np));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      rstn_v[u] = 1'b0; start_v[u] = 1'b0; resp_v[u] = 1'b0;
    end
    //          start resp  busy  done  pat   cnt sig       tog_ok tog
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 0, 16'h0000, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1, 16'h0001, 1'b0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 2, 16'h0003, 1'b1, 32'd2};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2, 16'h0003, 1'b1, 32'd2};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 0, 16'h0000, 1'b0, 32'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1, 16'h0000, 1'b0, 32'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 2, 16'h0001, 1'b1, 32'd2};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2, 16'h0001, 1'b1, 32'd2};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2, 16'h0001, 1'b1, 32'd2};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2, 16'h0001, 1'b1, 32'd2};

    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d_rst_busy", u), 32'(busy_v[u]), 32'd0);
      chk($sformatf("u%0d_rst_done", u), 32'(done_v[u]), 32'd0);
      chk($sformatf("u%0d_rst_pat", u), 32'(pat_v[u]), 32'd0);
      chk($sformatf("u%0d_rst_cnt", u), 32'(cnt_v[u]), 32'd0);
      chk($sformatf("u%0d_rst_sig", u), 32'(sig_v[u]), 32'd0);
`ifdef SUBCKT_TOGGLE_CNT_EN
      chk($sformatf("u%0d_rst_tog", u), tog_v[u], 32'd0);
`endif
      rstn_v[u] = 1'b1;
    end
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      start_v[1] = tbl[i].start;
      resp_v[1]  = tbl[i].resp;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), 32'(busy_v[1]), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(done_v[1]), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_pat", i), 32'(pat_v[1]), 32'(tbl[i].pat));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt_v[1]), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_sig", i), 32'(sig_v[1]), 32'(tbl[i].sig));
`ifdef SUBCKT_TOGGLE_CNT_EN
      if (tbl[i].tog_ok) chk($sformatf("tbl%0d_tog", i), tog_v[1], tbl[i].tog);
`endif
    end
    start_v[1] = 1'b0;
    resp_v[1]  = 1'b0;

    run_check(2, 4, 1);

    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    resp_v[2]  = 1'b1;
    repeat (2) @(negedge clk);
    rstn_v[2] = 1'b0;
    resp_v[2] = 1'b0;
    #1;
    chk("midrst_busy_async", 32'(busy_v[2]), 32'd0);
    chk("midrst_sig_async", 32'(sig_v[2]), 32'd0);
    @(negedge clk);
    chk("midrst_busy", 32'(busy_v[2]), 32'd0);
    chk("midrst_done", 32'(done_v[2]), 32'd0);
    chk("midrst_pat", 32'(pat_v[2]), 32'd0);
    chk("midrst_cnt", 32'(cnt_v[2]), 32'd0);
    chk("midrst_sig", 32'(sig_v[2]), 32'd0);
`ifdef SUBCKT_TOGGLE_CNT_EN
    chk("midrst_tog", tog_v[2], 32'd0);
`endif
    rstn_v[2] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_no_done", 32'(done_v[2]), 32'd0);
    end
    run_check(2, 4, 0);

    run_check(1, 2, 1);

    run_check(0, 256, 2);
    run_check(0, 256, 3);
    run_check(0, 256, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subckt_pattern_driver.md
# subckt_pattern_driver

Stimulus/response engine for the power-experiment sub-circuits: drives pseudo-random patterns into a combinational 4-input, 1-output sub-circuit and compacts the returned output bit into a signature. It sits in the experiment harness opposite the sub-circuit, sourcing its inputs and sinking its output. With the optional feature compiled in, it also counts input switching activity for power correlation.

## Interface
- N_IN, 4, width of pattern bus to the sub-circuit (1..16)
- NUM_PAT, 256, patterns per run (>=1; elaboration error if 0)
- SEED, 16'hACE1, LFSR value loaded on start (nonzero)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted through DONE
- done  out  1  one-cycle pulse at end of run
- pat_out  out  N_IN  pattern to the sub-circuit inputs (registered)
- resp_in  in  1  sub-circuit output
- signature  out  16  MISR contents
- pat_cnt  out  $clog2(NUM_PAT+1)  patterns applied in current/last run
- toggle_cnt  out  32  input bit transitions (only with SUBCKT_TOGGLE_CNT_EN)

## Operation
- Reset values: all outputs 0, state IDLE, lfsr = SEED.
- FSM: IDLE -> RUN on start; RUN -> DONE after pat_cnt reaches NUM_PAT; DONE -> IDLE unconditionally.
- On start accept: lfsr <= SEED, signature <= 0, pat_cnt <= 0, toggle_cnt <= 0.
- LFSR: Galois, right shift; lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0). Advances once per RUN cycle.
- pat_out = lfsr[N_IN-1:0] during RUN; 0 in IDLE and DONE.
- MISR, once per RUN cycle, capturing resp_in for the pattern on pat_out that cycle: m = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0); sig <= m ^ {15'b0, resp_in}.
- pat_cnt increments each RUN cycle; saturates at NUM_PAT.
- signature and pat_cnt hold after DONE until next accepted start.
- start while busy: ignored, no effect. start asserted in DONE: ignored; must be reasserted in IDLE.
- Reset mid-run: run abandoned, all state to reset values, no done pulse.

## Timing
- start high in IDLE at edge 0 -> first pattern on pat_out, busy=1, after edge 0.
- Pattern k (k=1..NUM_PAT) is stable for exactly one cycle; resp_in sampled at the closing edge of that cycle (DUT is combinational, single-cycle path).
- done=1 in the cycle after the last pattern (cycle NUM_PAT+1 after accept); busy deasserts with done.
- Back-to-back: earliest next accept is the first IDLE cycle, i.e. NUM_PAT+2 cycles between accepts.

## Configuration
- SUBCKT_TOGGLE_CNT_EN defined: toggle_cnt port present; each RUN cycle adds popcount(pat_out_next ^ pat_out) for the transition into the next RUN pattern, with the IDLE->first-pattern transition counted and the last-pattern->DONE transition not counted; saturates at 2^32-1.
- Undefined: toggle_cnt port and all related logic absent; other behaviour identical.

## Structure
- Shared package subckt_pkg: LFSR_POLY (16'hB400), MISR_POLY (16'h1021), state enum {IDLE, RUN, DONE}.
- One sub-module: subckt_misr (16-bit serial-input MISR with clear and enable). LFSR and counters inline.

## Test plan
- Reset: assert rst_n=0 mid-run -> all outputs 0 next cycle, no done; release, start -> normal run.
- Pattern sequence: SEED=16'hACE1, N_IN=4, NUM_PAT=2 -> pat_out 4'h1 then 4'h0, done at cycle 3, pat_cnt=2.
- MISR: resp_in tied 1, NUM_PAT=2 -> signature 16'h0003; resp_in tied 0, NUM_PAT=4 -> 16'h0000.
- Golden DUT: bench model resp = (p[1]~^p[2]) & ((p[0]&p[3]) | (p[0]^p[1])), NUM_PAT=256 -> signature equals bench MISR model; a single-bit fault in the model yields mismatch.
- Handshake: start held high throughout run, and pulsed in DONE -> exactly one run per IDLE accept; busy/done timing per above.
- SUBCKT_TOGGLE_CNT_EN: SEED=16'hACE1, NUM_PAT=2 -> toggle_cnt=2; build without macro compiles and passes other tests.
